// File: rtl/ame_scale_pkg.sv
// Shared types for the ame scaler scheduler: FSM state encoding, the
// {M,D,L,C} operand quad and the shift-amount width of the default build.
package ame_scale_pkg;

    localparam int DEF_COMP_DATA_BITS = 64;
    localparam int SHIFT_BITS         = $clog2(DEF_COMP_DATA_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_e;

    // Index 3 = M, 2 = D, 1 = L, 0 = C.
    typedef logic [3:0][DEF_COMP_DATA_BITS-1:0] comp_quad_t;

endpackage

// File: rtl/ame_rr_arb.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping explicitly at NUM_REQ-1 so non-power-of-two lane counts work.
module ame_rr_arb #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    int               j;
    logic [IDX_W-1:0] jj;

    // Scan lanes starting at the pointer; the first valid one wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = 0;
        jj      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr_i) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            jj = IDX_W'(j);
            if (!any_o && req_i[jj]) begin
                any_o       = 1'b1;
                grant_o[jj] = 1'b1;
                idx_o       = jj;
            end
        end
    end

endmodule

// File: rtl/ame_scale_sched.sv
// Round-robin scheduler sharing one ame_num_scale between NUM_REQ solver
// lanes, with a watchdog that turns a missing scale_done_i into a tagged
// timeout result.
// Optional feature macro: AME_SCALE_SCHED_STAT_EN adds per-lane saturating
// counters of handed-off results whose shift was non-zero.
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high. req_ready_o is only asserted in IDLE for the granted lane; rsp_* is
// held stable from rsp_valid_o rising until the cycle rsp_ready_i is seen.
module ame_scale_sched
    import ame_scale_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int COMP_DATA_BITS = DEF_COMP_DATA_BITS,
    parameter  int TIMEOUT_CYCLES = 15,
    localparam int IDX_W          = $clog2(NUM_REQ),
    localparam int SH_W           = $clog2(COMP_DATA_BITS)
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic [NUM_REQ-1:0]                        req_valid_i,
    output logic [NUM_REQ-1:0]                        req_ready_o,
    input  logic [NUM_REQ-1:0][3:0][COMP_DATA_BITS-1:0] req_data_i,
    output logic                                      rsp_valid_o,
    input  logic                                      rsp_ready_i,
    output logic [IDX_W-1:0]                          rsp_id_o,
    output logic [SH_W-1:0]                           rsp_shift_o,
    output logic [3:0][COMP_DATA_BITS-1:0]            rsp_data_o,
    output logic                                      rsp_timeout_o,
    output logic                                      scale_init_o,
    output logic [3:0][COMP_DATA_BITS-1:0]            scale_data_o,
    input  logic                                      scale_done_i,
    input  logic [SH_W-1:0]                           scale_shift_i,
    input  logic [3:0][COMP_DATA_BITS-1:0]            scale_data_i,
    output sched_state_e                              dbg_state_o
`ifdef AME_SCALE_SCHED_STAT_EN
    ,
    output logic [NUM_REQ-1:0][15:0]                  stat_sat_cnt_o
`endif
);

    sched_state_e                   state_q;
    logic [IDX_W-1:0]               rr_ptr_q;
    logic [IDX_W-1:0]               rr_ptr_d;
    logic [IDX_W-1:0]               id_q;
    logic [7:0]                     wd_cnt_q;
    logic                           scale_init_q;
    logic [3:0][COMP_DATA_BITS-1:0] scale_data_q;
    logic                           rsp_valid_q;
    logic                           rsp_timeout_q;
    logic [IDX_W-1:0]               rsp_id_q;
    logic [SH_W-1:0]                rsp_shift_q;
    logic [3:0][COMP_DATA_BITS-1:0] rsp_data_q;

    logic [NUM_REQ-1:0]             grant;
    logic [IDX_W-1:0]               grant_idx;
    logic                           grant_any;

    ame_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i   (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    // Pointer moves to the lane after the winner, wrapping explicitly.
    always_comb begin
        rr_ptr_d = grant_idx + 1'b1;
        if (grant_idx == IDX_W'(NUM_REQ - 1)) begin
            rr_ptr_d = '0;
        end
    end

    // Grant is only visible in IDLE; reset masks it so all outputs read 0.
    always_comb begin
        req_ready_o = '0;
        if (state_q == IDLE && !rst_i) begin
            req_ready_o = grant;
        end
    end

    // Scheduler FSM with watchdog; every output it drives is registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            id_q          <= '0;
            wd_cnt_q      <= '0;
            scale_init_q  <= 1'b0;
            scale_data_q  <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_id_q      <= '0;
            rsp_shift_q   <= '0;
            rsp_data_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        scale_data_q <= req_data_i[grant_idx];
                        id_q         <= grant_idx;
                        rr_ptr_q     <= rr_ptr_d;
                        scale_init_q <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    scale_init_q <= 1'b0;
                    wd_cnt_q     <= '0;
                    state_q      <= WAIT;
                end
                WAIT: begin
                    if (scale_done_i) begin
                        rsp_data_q    <= scale_data_i;
                        rsp_shift_q   <= scale_shift_i;
                        rsp_id_q      <= id_q;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= RESP;
                    end else if (wd_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                        // Scaler never answered: report a zeroed timeout result.
                        rsp_data_q    <= '0;
                        rsp_shift_q   <= '0;
                        rsp_id_q      <= id_q;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= RESP;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q   <= 1'b0;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign scale_init_o  = scale_init_q;
    assign scale_data_o  = scale_data_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign rsp_id_o      = rsp_id_q;
    assign rsp_shift_o   = rsp_shift_q;
    assign rsp_data_o    = rsp_data_q;
    assign dbg_state_o   = state_q;

`ifdef AME_SCALE_SCHED_STAT_EN
    logic [NUM_REQ-1:0][15:0] stat_q;

    // Count handed-off, non-timeout results that needed a shift; saturate.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_q <= '0;
        end else if (rsp_valid_q && rsp_ready_i && !rsp_timeout_q &&
                     rsp_shift_q != '0 && stat_q[rsp_id_q] != 16'hFFFF) begin
            stat_q[rsp_id_q] <= stat_q[rsp_id_q] + 16'd1;
        end
    end

    assign stat_sat_cnt_o = stat_q;
`endif

endmodule

// File: tb/tb_ame_scale_sched.sv
// Directed bench for ame_scale_sched. A behavioural scaler stub answers an
// init pulse with done one cycle later; it can be told to withhold done, and
// extra done pulses can be injected to model a late scaler.
module tb_ame_scale_sched;
    import ame_scale_pkg::*;

    localparam int NR  = 4;
    localparam int DB  = 64;
    localparam int TO  = 15;
    localparam int SHW = SHIFT_BITS;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0]             req_valid;
    logic [NR-1:0]             req_ready;
    logic [NR-1:0][3:0][DB-1:0] req_data;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [1:0]                rsp_id;
    logic [SHW-1:0]            rsp_shift;
    comp_quad_t                rsp_data;
    logic                      rsp_timeout;
    logic                      scale_init;
    comp_quad_t                scale_data_o;
    logic                      scale_done;
    logic [SHW-1:0]            scale_shift;
    comp_quad_t                scale_data_i;
    sched_state_e              dbg_state;
`ifdef AME_SCALE_SCHED_STAT_EN
    logic [NR-1:0][15:0]       stat_cnt;
`endif

    ame_scale_sched #(.NUM_REQ(NR), .COMP_DATA_BITS(DB), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_data_i    (req_data),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_id_o      (rsp_id),
        .rsp_shift_o   (rsp_shift),
        .rsp_data_o    (rsp_data),
        .rsp_timeout_o (rsp_timeout),
        .scale_init_o  (scale_init),
        .scale_data_o  (scale_data_o),
        .scale_done_i  (scale_done),
        .scale_shift_i (scale_shift),
        .scale_data_i  (scale_data_i),
        .dbg_state_o   (dbg_state)
`ifdef AME_SCALE_SCHED_STAT_EN
        ,
        .stat_sat_cnt_o(stat_cnt)
`endif
    );

    // ---------------- scaler stub ----------------
    logic stub_done;
    logic stub_hold;
    logic inject_done;

    function automatic int bitlen(logic [DB-1:0] v);
        logic [DB-1:0] a;
        int n;
        a = v[DB-1] ? -v : v;
        n = 0;
        for (int i = 0; i < DB; i++) begin
            if (a[i]) n = i + 1;
        end
        return n;
    endfunction

    function automatic int stub_sh(comp_quad_t q);
        int s;
        s = bitlen(q[3]) + bitlen(q[2]);
        return (s > 44) ? s - 44 : 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_done    <= 1'b0;
            scale_shift  <= '0;
            scale_data_i <= '0;
        end else begin
            stub_done <= scale_init & ~stub_hold;
            if (scale_init) begin
                scale_shift     <= SHW'(stub_sh(scale_data_o));
                scale_data_i    <= scale_data_o;
                scale_data_i[3] <= $signed(scale_data_o[3]) >>> stub_sh(scale_data_o);
            end
        end
    end

    assign scale_done = stub_done | inject_done;

    // ---------------- scoreboard / checking ----------------
    int checks   = 0;
    int failures = 0;
    logic [1:0] exp_q[$];

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},   256'(req_ready),    256'(0));
        check({tag, "_rvalid"},  256'(rsp_valid),    256'(0));
        check({tag, "_rid"},     256'(rsp_id),       256'(0));
        check({tag, "_rshift"},  256'(rsp_shift),    256'(0));
        check({tag, "_rdata"},   256'(rsp_data),     256'(0));
        check({tag, "_rto"},     256'(rsp_timeout),  256'(0));
        check({tag, "_init"},    256'(scale_init),   256'(0));
        check({tag, "_sdata"},   256'(scale_data_o), 256'(0));
        check({tag, "_state"},   256'(dbg_state),    256'(IDLE));
    endtask

    comp_quad_t q1, q3, q4;
    int grant_n, last_grant, gap;
    logic [1:0] exp_grant [5];
    logic [1:0] g;

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        req_valid   = '0;
        req_data    = '0;
        rsp_ready   = 1'b1;
        stub_hold   = 1'b0;
        inject_done = 1'b0;
        exp_grant   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // Reset values, with every lane requesting.
        req_valid = 4'b1111;
        #12;
        check_all_zero("rst");
        req_valid = '0;
        do_reset();

        // 1. Single lane 2; nominal latency.
        q1 = {-64'sd1000, 64'd3, 64'd7, 64'd9};
        next_cyc();
        req_valid   = 4'b0100;
        req_data[2] = q1;
        #1;
        check("t1_ready_T", 256'(req_ready), 256'(4'b0100));
        next_cyc();
        req_valid = '0;
        req_data  = '0;
        #1;
        check("t1_init_T1",  256'(scale_init),   256'(1));
        check("t1_sdata_T1", 256'(scale_data_o), 256'(q1));
        next_cyc();
        #1;
        check("t1_init_T2",   256'(scale_init), 256'(0));
        check("t1_rvalid_T2", 256'(rsp_valid),  256'(0));
        next_cyc();
        #1;
        check("t1_rvalid_T3", 256'(rsp_valid), 256'(1));
        check("t1_rid",       256'(rsp_id),    256'(2));
        check("t1_rshift",    256'(rsp_shift), 256'(0));
        check("t1_rdata",     256'(rsp_data),  256'(q1));
        check("t1_rto",       256'(rsp_timeout), 256'(0));
        next_cyc();
        #1;
        check("t1_rvalid_T4", 256'(rsp_valid), 256'(0));
        check("t1_idle_T4",   256'(dbg_state), 256'(IDLE));

        // 2. All lanes valid from rr_ptr=0: order 0,1,2,3,0, spaced 4 cycles.
        do_reset();
        for (int l = 0; l < NR; l++) req_data[l] = {64'(l + 1), 64'd1, 64'd2, 64'(l)};
        grant_n    = 0;
        last_grant = -1;
        for (int c = 0; c < 20; c++) begin
            next_cyc();
            req_valid = 4'b1111;
            #1;
            check("t2_onehot0", 256'($onehot0(req_ready)), 256'(1));
            if (req_ready != '0) begin
                g = 2'(dut.grant_idx);
                if (grant_n < 5) check("t2_grant_order", 256'(req_ready), 256'(4'b0001 << exp_grant[grant_n]));
                if (last_grant >= 0) begin
                    gap = c - last_grant;
                    check("t2_grant_gap", 256'(gap), 256'(4));
                end
                last_grant = c;
                exp_q.push_back(exp_grant[grant_n % 5]);
                grant_n++;
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("t2_rsp_unexpected", 256'(1), 256'(0));
                end else begin
                    check("t2_rsp_id", 256'(rsp_id), 256'(exp_q.pop_front()));
                end
            end
        end
        req_valid = '0;
        check("t2_grant_count", 256'(grant_n), 256'(5));
        check("t2_queue_empty", 256'(exp_q.size()), 256'(0));
        repeat (4) next_cyc();

        // 3. Lane 1, M=2^40, D=2^20: shift 18, M'=2^22, D/L/C unchanged.
        q3 = {64'h100_0000_0000, 64'h10_0000, 64'd5, 64'd11};
        next_cyc();
        req_valid   = 4'b0010;
        req_data[1] = q3;
        #1;
        check("t3_ready", 256'(req_ready), 256'(4'b0010));
        next_cyc();
        req_valid = '0;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) break;
            next_cyc();
            #1;
        end
        check("t3_got_rsp", 256'(rsp_valid), 256'(1));
        check("t3_rid",     256'(rsp_id),    256'(1));
        check("t3_rshift",  256'(rsp_shift), 256'(18));
        check("t3_rdata",   256'(rsp_data),  256'({64'h40_0000, 64'h10_0000, 64'd5, 64'd11}));
        next_cyc();
        #1;

        // 4. Back-pressure: rsp held 10 cycles, no grants while waiting.
        rsp_ready = 1'b0;
        q4 = {64'd100, 64'd4, 64'd6, 64'd8};
        next_cyc();
        req_valid   = 4'b0001;
        req_data[0] = q4;
        #1;
        check("t4_ready", 256'(req_ready), 256'(4'b0001));
        next_cyc();
        req_valid = '0;
        #1;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid) break;
            next_cyc();
            #1;
        end
        check("t4_got_rsp", 256'(rsp_valid), 256'(1));
        for (int i = 0; i < 10; i++) begin
            next_cyc();
            req_valid = 4'b1001;
            #1;
            check("t4_hold_valid", 256'(rsp_valid), 256'(1));
            check("t4_hold_data",  256'({rsp_id, rsp_shift, rsp_data}), 256'({2'd0, 6'd0, q4}));
            check("t4_no_grant",   256'(req_ready), 256'(0));
        end
        next_cyc();
        rsp_ready = 1'b1;
        #1;
        check("t4_release_no_grant", 256'(req_ready), 256'(0));
        next_cyc();
        #1;
        check("t4_idle_after", 256'(dbg_state), 256'(IDLE));
        check("t4_rvalid_clr", 256'(rsp_valid), 256'(0));
        check("t4_next_grant", 256'(req_ready), 256'(4'b1000));
        next_cyc();
        req_valid = '0;
        repeat (4) next_cyc();
`ifdef AME_SCALE_SCHED_STAT_EN
        #1;
        check("stat_lane1", 256'(stat_cnt[1]), 256'(1));
        check("stat_lane0", 256'(stat_cnt[0]), 256'(0));
`endif

        // 5. Scaler withholds done: timeout after 15 WAIT cycles, late done dropped.
        stub_hold = 1'b1;
        rsp_ready = 1'b0;
        next_cyc();
        req_valid = 4'b0100;
        #1;
        check("t5_ready", 256'(req_ready), 256'(4'b0100));
        next_cyc();
        req_valid = '0;
        #1;
        check("t5_init", 256'(scale_init), 256'(1));
        for (int k = 1; k <= 15; k++) begin
            next_cyc();
            #1;
            if (k == 15) check("t5_not_yet", 256'(rsp_valid), 256'(0));
        end
        next_cyc();
        #1;
        check("t5_rvalid",  256'(rsp_valid),   256'(1));
        check("t5_timeout", 256'(rsp_timeout), 256'(1));
        check("t5_rdata",   256'(rsp_data),    256'(0));
        check("t5_rshift",  256'(rsp_shift),   256'(0));
        check("t5_rid",     256'(rsp_id),      256'(2));
        next_cyc();
        inject_done = 1'b1;
        next_cyc();
        inject_done = 1'b0;
        #1;
        check("t5_late_to",   256'(rsp_timeout), 256'(1));
        check("t5_late_data", 256'(rsp_data),    256'(0));
        rsp_ready = 1'b1;
        next_cyc();
        #1;
        check("t5_rvalid_clr", 256'(rsp_valid),   256'(0));
        check("t5_to_clr",     256'(rsp_timeout), 256'(0));
        inject_done = 1'b1;
        next_cyc();
        inject_done = 1'b0;
        next_cyc();
        #1;
        check("t5_idle_done_ignored", 256'(rsp_valid), 256'(0));
        check("t5_idle_state",        256'(dbg_state), 256'(IDLE));

        // 6. Asynchronous reset while waiting on the scaler.
        next_cyc();
        req_valid = 4'b0100;
        next_cyc();
        req_valid = '0;
        repeat (3) next_cyc();
        #1;
        check("t6_in_wait", 256'(dbg_state), 256'(WAIT));
        req_valid = 4'b1111;
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("t6_rst");
`ifdef AME_SCALE_SCHED_STAT_EN
        check("t6_stat_clr", 256'(stat_cnt), 256'(0));
`endif
        @(posedge clk);
        #1;
        rst       = 1'b0;
        stub_hold = 1'b0;
        #1;
        check("t6_first_grant", 256'(req_ready), 256'(4'b0001));
        next_cyc();
        req_valid = '0;
        repeat (5) next_cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
